clock_mode_controller: RTL and testbench
========================================

CLOCK_MODE_CONTROLLER -- requirements
Module: clock_mode_controller

Interface
REQ-001 Parameter P_COUNT_BIT, default 30, SHALL set the width of the tick-generator divisor.
REQ-002 Parameter P_FREQ_NORMAL, default 100_000_000, SHALL be the divisor for real-time seconds.
REQ-003 Parameter P_FREQ_FAST, default 1_000_000, SHALL be the divisor for fast-forward.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous and active-low (0 = reset).
REQ-006 i_tick  input  1  SHALL be the one-cycle one-second pulse from the tick generator.
REQ-007 i_mode  input  1  SHALL be a one-cycle button pulse that advances the mode.
REQ-008 i_up  input  1  SHALL be a one-cycle button pulse that increments the selected field.
REQ-009 i_fast  input  1  SHALL be a level request for fast-forward divisor.
REQ-010 o_gen_en  output  1  SHALL be the tick-generator enable.
REQ-011 o_freq  output  P_COUNT_BIT  SHALL be the divisor driven to the tick generator.
REQ-012 o_sec  output  6 / o_min  output  6 / o_hour  output  5  SHALL be the current time, binary.
REQ-013 o_mode  output  2  SHALL expose the FSM state encoding.
REQ-014 o_day  output  1  SHALL pulse one cycle on 23:59:59 -> 00:00:00 rollover.

Function
REQ-015 FSM states SHALL be RUN=0, SET_H=1, SET_M=2, SET_S=3; i_mode SHALL step RUN->SET_H->SET_M->SET_S->RUN.
REQ-016 In RUN, i_tick SHALL increment o_sec on the next clock edge (latency 1 cycle).
REQ-017 Seconds SHALL wrap 59->0 with carry to o_min; minutes 59->0 with carry to o_hour; hours 23->0 with o_day asserted the same cycle as the wrap.
REQ-018 In any SET state, i_tick SHALL be ignored and o_gen_en SHALL be 0; in RUN o_gen_en SHALL be 1.
REQ-019 i_up in SET_H/SET_M/SET_S SHALL increment only that field, wrapping at 23/59/59, with no carry and no o_day.
REQ-020 i_up in RUN SHALL be ignored.
REQ-021 Simultaneous i_mode and i_up SHALL apply the mode change only; i_up dropped.
REQ-022 Simultaneous i_tick and i_mode in RUN SHALL apply the time increment and the mode change in the same cycle.
REQ-023 Entering SET_S SHALL NOT clear o_sec; returning to RUN SHALL resume counting from the set values.
REQ-024 o_freq SHALL be registered: P_FREQ_FAST when i_fast=1 in RUN, else P_FREQ_NORMAL, updating one cycle after i_fast changes.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 On reset=0 asynchronously: state RUN, o_sec/o_min/o_hour=0, o_day=0, o_gen_en=0, o_freq=P_FREQ_NORMAL.
REQ-027 o_gen_en SHALL go to 1 on the first clock edge after reset deasserts.
REQ-028 Reset asserted mid-operation (any state, mid-carry) SHALL discard all pending increments.

Structure
REQ-029 A shared package clock_pkg SHALL hold the state encoding, field maxima (23, 59), and field widths.
REQ-030 A sub-module time_field_counter (parameterised modulus, inc in, carry out, value out) SHALL be instantiated three times for sec/min/hour.

Verification
REQ-031 Reset released, 3 i_tick pulses in RUN -> o_sec=3, o_min=0, o_gen_en=1.
REQ-032 Preload 23:59:59 via SET states, return to RUN, one i_tick -> 00:00:00 and o_day high exactly one cycle.
REQ-033 In SET_M at o_min=59, one i_up -> o_min=0, o_hour unchanged; i_tick pulses ignored, o_gen_en=0.
REQ-034 i_mode and i_up asserted the same cycle in SET_H -> state SET_M, o_hour unchanged.
REQ-035 i_fast=1 in RUN -> o_freq=1_000_000 one cycle later; i_mode to SET_H -> o_freq=100_000_000.
REQ-036 Assert reset=0 at 12:34:56 in SET_S -> all outputs to reset values immediately, state RUN.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock mode controller: mode encoding,
// time-field widths and the wrap values of each field.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // RUN -> SET_H -> SET_M -> SET_S -> RUN, using the natural 2-bit wrap.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/time_field_counter.sv
// Modulo-(P_MAX+1) counter for one time field; carry is high during the
// cycle in which an increment wraps the field back to zero.
module time_field_counter #(
    parameter int P_WIDTH = 6,
    parameter int P_MAX   = 59
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic               carry,
    output logic [P_WIDTH-1:0] value
);

    localparam logic [P_WIDTH-1:0] MAX_V = P_WIDTH'(P_MAX);

    assign carry = inc && (value == MAX_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (inc) begin
            value <= carry ? '0 : value + P_WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_mode_controller.sv
// Time-of-day keeper with a RUN/SET mode machine; drives the enable and
// divisor of an external one-second tick generator.
module clock_mode_controller
    import clock_pkg::*;
#(
    parameter int P_COUNT_BIT   = 30,
    parameter int P_FREQ_NORMAL = 100_000_000,
    parameter int P_FREQ_FAST   = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_tick,
    input  logic                   i_mode,
    input  logic                   i_up,
    input  logic                   i_fast,
    output logic                   o_gen_en,
    output logic [P_COUNT_BIT-1:0] o_freq,
    output logic [SEC_W-1:0]       o_sec,
    output logic [MIN_W-1:0]       o_min,
    output logic [HOUR_W-1:0]      o_hour,
    output logic [1:0]             o_mode,
    output logic                   o_day
);

    localparam logic [P_COUNT_BIT-1:0] FREQ_N = P_COUNT_BIT'(P_FREQ_NORMAL);
    localparam logic [P_COUNT_BIT-1:0] FREQ_F = P_COUNT_BIT'(P_FREQ_FAST);

    mode_t state, next_state;

    logic run_tick, up_ok;
    logic sec_inc, min_inc, hour_inc;
    logic sec_carry, min_carry, hour_carry;
    logic gen_en_d, day_d;
    logic [P_COUNT_BIT-1:0] freq_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (i_mode) begin
            next_state = next_mode(state);
        end
    end

    // A mode press in the same cycle swallows i_up; ticks only count in RUN.
    assign run_tick = (state == RUN) && i_tick;
    assign up_ok    = i_up && !i_mode;
    assign sec_inc  = run_tick || ((state == SET_S) && up_ok);
    assign min_inc  = (run_tick && sec_carry) || ((state == SET_M) && up_ok);
    assign hour_inc = (run_tick && sec_carry && min_carry) || ((state == SET_H) && up_ok);

    always_comb begin
        gen_en_d = (next_state == RUN);
        freq_d   = (gen_en_d && i_fast) ? FREQ_F : FREQ_N;
        day_d    = run_tick && sec_carry && min_carry && hour_carry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_gen_en <= 1'b0;
            o_freq   <= FREQ_N;
            o_day    <= 1'b0;
        end else begin
            o_gen_en <= gen_en_d;
            o_freq   <= freq_d;
            o_day    <= day_d;
        end
    end

    assign o_mode = state;

    time_field_counter #(.P_WIDTH(SEC_W), .P_MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .carry (sec_carry),
        .value (o_sec)
    );

    time_field_counter #(.P_WIDTH(MIN_W), .P_MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .carry (min_carry),
        .value (o_min)
    );

    time_field_counter #(.P_WIDTH(HOUR_W), .P_MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .reset (reset),
        .inc   (hour_inc),
        .carry (hour_carry),
        .value (o_hour)
    );

endmodule

// File: tb/tb_clock_mode_controller.sv
// Bench for clock_mode_controller: a reference time/mode model pushes the
// expected output snapshot per driven cycle; each test pops and compares.
module tb_clock_mode_controller;

    localparam int CB = 30;
    localparam int FN = 100_000_000;
    localparam int FF = 1_000_000;
    localparam int W  = 51;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_tick = 1'b0, i_mode = 1'b0, i_up = 1'b0, i_fast = 1'b0;
    logic          o_gen_en, o_day;
    logic [CB-1:0] o_freq;
    logic [5:0]    o_sec, o_min;
    logic [4:0]    o_hour;
    logic [1:0]    o_mode;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    int            m_mode, m_h, m_m, m_s;
    logic          m_gen, m_day;
    logic [CB-1:0] m_freq;

    clock_mode_controller #(
        .P_COUNT_BIT(CB), .P_FREQ_NORMAL(FN), .P_FREQ_FAST(FF)
    ) dut (
        .clk(clk), .reset(reset), .i_tick(i_tick), .i_mode(i_mode),
        .i_up(i_up), .i_fast(i_fast), .o_gen_en(o_gen_en), .o_freq(o_freq),
        .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode),
        .o_day(o_day)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] snap_dut();
        return {o_mode, o_gen_en, o_day, o_hour, o_min, o_sec, o_freq};
    endfunction

    function automatic logic [W-1:0] snap_model();
        return {2'(m_mode), m_gen, m_day, 5'(m_h), 6'(m_m), 6'(m_s), m_freq};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
        m_gen = 1'b0; m_day = 1'b0; m_freq = CB'(FN);
    endtask

    task automatic model_step(input logic t, input logic md, input logic u, input logic f);
        logic up_ok;
        up_ok = u && !md;
        m_day = 1'b0;
        if (m_mode == 0 && t) begin
            m_s++;
            if (m_s == 60) begin
                m_s = 0; m_m++;
                if (m_m == 60) begin
                    m_m = 0; m_h++;
                    if (m_h == 24) begin
                        m_h = 0; m_day = 1'b1;
                    end
                end
            end
        end
        if (up_ok && m_mode == 1) m_h = (m_h + 1) % 24;
        if (up_ok && m_mode == 2) m_m = (m_m + 1) % 60;
        if (up_ok && m_mode == 3) m_s = (m_s + 1) % 60;
        if (md) m_mode = (m_mode + 1) % 4;
        m_gen  = (m_mode == 0);
        m_freq = (m_gen && f) ? CB'(FF) : CB'(FN);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rise.
    task automatic drive_cycle(input logic t, input logic md, input logic u, input logic f);
        @(negedge clk);
        i_tick = t; i_mode = md; i_up = u; i_fast = f;
        model_step(t, md, u, f);
        exp_q.push_back(snap_model());
        @(posedge clk);
        #1;
        i_tick = 1'b0; i_mode = 1'b0; i_up = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp, obs;
        reset = 1'b0;
        model_reset();
        exp_q.push_back(snap_model());
        #12;
        exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL reset_hold: got %h want %h", obs, exp);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL reset_release: got %h want %h", obs, exp);
        end
    endtask

    task automatic back_to_run(input logic f);
        logic [W-1:0] exp, obs;
        while (m_mode != 0) begin
            drive_cycle(1'b0, 1'b1, 1'b0, f);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL back_to_run: got %h want %h", obs, exp);
            end
        end
    endtask

    // Starting from RUN, walks the SET states and ends in SET_S at h:m:s.
    task automatic set_time(input int h, input int m, input int s);
        logic [3:0] acts[$];
        logic [W-1:0] exp, obs;
        acts.push_back(4'b0100);
        repeat ((h - m_h + 24) % 24) acts.push_back(4'b0010);
        acts.push_back(4'b0100);
        repeat ((m - m_m + 60) % 60) acts.push_back(4'b0010);
        acts.push_back(4'b0100);
        repeat ((s - m_s + 60) % 60) acts.push_back(4'b0010);
        foreach (acts[k]) begin
            drive_cycle(acts[k][3], acts[k][2], acts[k][1], acts[k][0]);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL set_time step %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_tick_count();
        logic [W-1:0] exp, obs;
        for (int i = 0; i < 4; i++) begin
            // Fourth step is an i_up in RUN, which must leave time untouched.
            drive_cycle(i < 3, 1'b0, i == 3, 1'b0);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL tick_count %0d: got %h want %h", i, obs, exp);
            end
        end
        n_cmp++;
        if ({o_sec, o_min, o_gen_en} !== {6'd3, 6'd0, 1'b1}) begin
            n_bad++; $display("FAIL three_ticks: got sec=%0d min=%0d gen=%b want 3 0 1", o_sec, o_min, o_gen_en);
        end
    endtask

    task automatic test_day_rollover();
        logic [W-1:0] exp, obs;
        set_time(23, 59, 59);
        back_to_run(1'b0);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(i == 0, 1'b0, 1'b0, 1'b0);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL rollover %0d: got %h want %h", i, obs, exp);
            end
            n_cmp++;
            if ({o_hour, o_min, o_sec, o_day} !== {5'd0, 6'd0, 6'd0, (i == 0)}) begin
                n_bad++; $display("FAIL day_pulse %0d: got %0d:%0d:%0d day=%b", i, o_hour, o_min, o_sec, o_day);
            end
        end
    endtask

    task automatic test_set_min_wrap();
        logic [W-1:0] exp, obs;
        set_time(5, 59, 10);
        back_to_run(1'b0);
        for (int i = 0; i < 6; i++) begin
            // mode, mode -> SET_M; up wraps minutes; three ticks ignored
            drive_cycle(i >= 3, i < 2, i == 2, 1'b0);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL set_min %0d: got %h want %h", i, obs, exp);
            end
        end
        n_cmp++;
        if ({o_mode, o_hour, o_min, o_sec, o_gen_en} !== {2'd2, 5'd5, 6'd0, 6'd10, 1'b0}) begin
            n_bad++; $display("FAIL min_wrap: got mode=%0d %0d:%0d:%0d gen=%b", o_mode, o_hour, o_min, o_sec, o_gen_en);
        end
        back_to_run(1'b0);
    endtask

    task automatic test_mode_up_same();
        logic [W-1:0] exp, obs;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b1, i == 1, 1'b0);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL mode_up %0d: got %h want %h", i, obs, exp);
            end
        end
        n_cmp++;
        if ({o_mode, o_hour} !== {2'd2, 5'd5}) begin
            n_bad++; $display("FAIL mode_up_drop: got mode=%0d hour=%0d want 2 5", o_mode, o_hour);
        end
        back_to_run(1'b0);
    endtask

    task automatic test_tick_mode_same();
        logic [W-1:0] exp, obs;
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL tick_mode: got %h want %h", obs, exp);
        end
        back_to_run(1'b0);
    endtask

    task automatic test_fast();
        logic [W-1:0] exp, obs;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, i == 1, 1'b0, i < 2);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL fast %0d: got %h want %h", i, obs, exp);
            end
            if (i < 2) begin
                n_cmp++;
                if (o_freq !== ((i == 0) ? CB'(FF) : CB'(FN))) begin
                    n_bad++; $display("FAIL freq_sel %0d: got %0d", i, o_freq);
                end
            end
        end
        back_to_run(1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] exp, obs;
        logic t, md, u, f;
        for (int i = 0; i < 200; i++) begin
            t  = 1'($urandom_range(0, 1));
            md = ($urandom_range(0, 7) == 0);
            u  = 1'($urandom_range(0, 1));
            f  = 1'($urandom_range(0, 1));
            drive_cycle(t, md, u, f);
            exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL random %0d: got %h want %h", i, obs, exp);
            end
        end
        back_to_run(1'b0);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp, obs;
        set_time(12, 34, 56);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        exp_q.push_back(snap_model());
        #1;
        exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL async_reset: got %h want %h", obs, exp);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        exp = exp_q.pop_front(); obs = snap_dut(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL after_reset: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_tick_count();
        test_day_rollover();
        test_set_min_wrap();
        test_mode_up_same();
        test_tick_mode_same();
        test_fast();
        test_random();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
